// File: rtl/tile_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tile_job_scheduler
//  Description : Job FIFO feeding TILE im2col/PE tiles. Each tile is driven
//                through an HLS start/ready/done handshake. Finished tiles
//                are arbitrated round-robin onto one completion stream, and
//                each tile is released with an output_taken pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_job_scheduler #(
    parameter int TILE   = 4,
    parameter int JOB_W  = 16,
    parameter int QDEPTH = 8,
    parameter int TW     = $clog2(TILE),
    parameter int QW     = $clog2(QDEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [JOB_W-1:0] job_id,
    output logic [TILE-1:0]  tile_start,
    input  logic [TILE-1:0]  tile_ready,
    input  logic [TILE-1:0]  tile_done,
    output logic [TILE-1:0]  tile_output_taken,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [TW-1:0]    done_tile,
    output logic [JOB_W-1:0] done_job,
    output logic [QW:0]      jobs_pending,
    output logic             busy
);

    // Per-tile lifecycle: free, start offered, computing, waiting for release
    typedef enum logic [1:0] {
        TS_IDLE   = 2'd0,
        TS_LAUNCH = 2'd1,
        TS_RUN    = 2'd2,
        TS_DONE   = 2'd3
    } tile_state_t;

    // ------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------
    logic [JOB_W-1:0] fifo_mem [QDEPTH];
    logic [QW-1:0]    wr_ptr;
    logic [QW-1:0]    rd_ptr;
    logic [QW:0]      fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [JOB_W-1:0] fifo_head;
    logic             push;
    logic             pop;
    logic             ready_en;

    logic [TILE-1:0]  tile_idle;
    logic [TILE-1:0]  tile_fin;
    logic [JOB_W-1:0] tile_job [TILE];

    logic [TW-1:0]    dpt_ptr;
    logic             dpt_found;
    logic [TW-1:0]    dpt_sel;
    logic [TILE-1:0]  dpt_onehot;

    logic [TW-1:0]    cmp_ptr;
    logic             cmp_found;
    logic [TW-1:0]    cmp_sel;
    logic [TILE-1:0]  cmp_onehot;
    logic             out_free;

    // Round-robin helper: (base + offs) mod TILE, without a divider
    function automatic logic [TW-1:0] rr_index(input logic [TW-1:0] base, input int offs);
        logic [TW:0] s;
        s = {1'b0, base} + (TW+1)'(offs);
        if (s >= (TW+1)'(TILE)) begin
            s = s - (TW+1)'(TILE);
        end
        return s[TW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == (QW+1)'(QDEPTH));
    assign fifo_head    = fifo_mem[rd_ptr];
    // ready_en keeps job_ready low while in reset and until the first edge after it
    assign job_ready    = ready_en && !fifo_full;
    assign push         = job_valid && job_ready;
    assign pop          = dpt_found;
    assign jobs_pending = fifo_count;

    // FIFO pointers, occupancy and the post-reset enable for job_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= job_id;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch: first IDLE tile at or above dpt_ptr, with wrap
    // ------------------------------------------------------------------
    // Pick the dispatch target for this cycle
    always_comb begin
        dpt_found = 1'b0;
        dpt_sel   = '0;
        if (!fifo_empty) begin
            for (int k = 0; k < TILE; k++) begin
                if (!dpt_found && tile_idle[rr_index(dpt_ptr, k)]) begin
                    dpt_found = 1'b1;
                    dpt_sel   = rr_index(dpt_ptr, k);
                end
            end
        end
    end

    // One-hot form of the dispatch decision for the tile FSMs
    always_comb begin
        dpt_onehot = '0;
        if (dpt_found) begin
            dpt_onehot[dpt_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completion arbitration: first DONE tile at or above cmp_ptr
    // ------------------------------------------------------------------
    // The output register may load when empty or being drained this cycle
    assign out_free = !done_valid || done_ready;

    // Pick the completion winner for this cycle
    always_comb begin
        cmp_found = 1'b0;
        cmp_sel   = '0;
        if (out_free) begin
            for (int k = 0; k < TILE; k++) begin
                if (!cmp_found && tile_fin[rr_index(cmp_ptr, k)]) begin
                    cmp_found = 1'b1;
                    cmp_sel   = rr_index(cmp_ptr, k);
                end
            end
        end
    end

    // One-hot grant back to the winning tile
    always_comb begin
        cmp_onehot = '0;
        if (cmp_found) begin
            cmp_onehot[cmp_sel] = 1'b1;
        end
    end

    // Round-robin pointers advance past the tile just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dpt_ptr <= '0;
            cmp_ptr <= '0;
        end else begin
            if (dpt_found) begin
                dpt_ptr <= rr_index(dpt_sel, 1);
            end
            if (cmp_found) begin
                cmp_ptr <= rr_index(cmp_sel, 1);
            end
        end
    end

    // Job tag captured when a tile is launched; only read once that tile is DONE
    always_ff @(posedge clk) begin
        if (dpt_found) begin
            tile_job[dpt_sel] <= fifo_head;
        end
    end

    // Completion record register and the release pulse to the granted tile
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_valid        <= 1'b0;
            done_tile         <= '0;
            done_job          <= '0;
            tile_output_taken <= '0;
        end else begin
            tile_output_taken <= cmp_onehot;
            if (cmp_found) begin
                done_valid <= 1'b1;
                done_tile  <= cmp_sel;
                done_job   <= tile_job[cmp_sel];
            end else if (done_ready) begin
                done_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-tile handshake FSMs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < TILE; gi++) begin : g_tile
        tile_state_t state_q;
        tile_state_t state_d;

        // State register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= TS_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state; tile_done is only honoured while a job is in flight
        always_comb begin
            state_d = state_q;
            case (state_q)
                TS_IDLE: begin
                    if (dpt_onehot[gi]) begin
                        state_d = TS_LAUNCH;
                    end
                end
                TS_LAUNCH: begin
                    if (tile_ready[gi]) begin
                        state_d = tile_done[gi] ? TS_DONE : TS_RUN;
                    end
                end
                TS_RUN: begin
                    if (tile_done[gi]) begin
                        state_d = TS_DONE;
                    end
                end
                TS_DONE: begin
                    if (cmp_onehot[gi]) begin
                        state_d = TS_IDLE;
                    end
                end
                default: state_d = TS_IDLE;
            endcase
        end

        assign tile_idle[gi]  = (state_q == TS_IDLE);
        assign tile_fin[gi]   = (state_q == TS_DONE);
        assign tile_start[gi] = (state_q == TS_LAUNCH);
    end

    assign busy = !fifo_empty || (tile_idle != {TILE{1'b1}}) || done_valid;

endmodule
`default_nettype wire
